// File: rtl/fdct_pkg.sv
// Shared constants and FSM state type for the 4-point forward DCT (fdct4_serial).
package fdct_pkg;

    localparam int C64       = 64;
    localparam int C83       = 83;
    localparam int C36       = 36;
    localparam int ACC_W     = 34;
    localparam int DEF_SHIFT = 12;
    localparam int DEF_ADD   = 2048;
    localparam int SAT_MAX   = 32767;
    localparam int SAT_MIN   = -32768;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        BFLY = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fdct4_serial_if.sv
// Sample-in / coefficient-out stream bundle for fdct4_serial; slave is the DCT side.
interface fdct4_serial_if #(
    parameter int DW = 25
) ();

    logic signed [DW-1:0] d_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] d_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_idx;
    logic                 out_last;

    modport slave (
        input  d_in, in_valid, out_ready,
        output in_ready, d_out, out_valid, out_idx, out_last
    );

    modport master (
        output d_in, in_valid, out_ready,
        input  in_ready, d_out, out_valid, out_idx, out_last
    );

endinterface

// File: rtl/fdct4_coef_mac.sv
// Combinational coefficient generator: selects y[idx] from the butterfly terms, rounds and shifts.
// Optional signed 16-bit output clamp when FDCT_SAT_EN is defined.
module fdct4_coef_mac
    import fdct_pkg::*;
#(
    parameter int DW    = 25,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ADD   = DEF_ADD
) (
    input  logic [1:0]           i_idx,
    input  logic signed [DW:0]   i_e0,
    input  logic signed [DW:0]   i_e1,
    input  logic signed [DW:0]   i_o0,
    input  logic signed [DW:0]   i_o1,
    output logic signed [DW-1:0] o_coef
);

    localparam logic signed [ACC_W-1:0] K64  = ACC_W'(C64);
    localparam logic signed [ACC_W-1:0] K83  = ACC_W'(C83);
    localparam logic signed [ACC_W-1:0] K36  = ACC_W'(C36);
    localparam logic signed [ACC_W-1:0] KADD = ACC_W'(ADD);

    logic signed [ACC_W-1:0] w_e0;
    logic signed [ACC_W-1:0] w_e1;
    logic signed [ACC_W-1:0] w_o0;
    logic signed [ACC_W-1:0] w_o1;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rnd;

    assign w_e0 = {{(ACC_W-DW-1){i_e0[DW]}}, i_e0};
    assign w_e1 = {{(ACC_W-DW-1){i_e1[DW]}}, i_e1};
    assign w_o0 = {{(ACC_W-DW-1){i_o0[DW]}}, i_o0};
    assign w_o1 = {{(ACC_W-DW-1){i_o1[DW]}}, i_o1};

    always_comb begin
        w_sum = '0;
        case (i_idx)
            2'd0:    w_sum = K64 * (w_e0 + w_e1);
            2'd1:    w_sum = (K83 * w_o0) + (K36 * w_o1);
            2'd2:    w_sum = K64 * (w_e0 - w_e1);
            default: w_sum = (K36 * w_o0) - (K83 * w_o1);
        endcase
    end

    assign w_rnd = w_sum + KADD;

`ifdef FDCT_SAT_EN
    localparam logic signed [ACC_W-1:0] KMAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] KMIN = ACC_W'(SAT_MIN);

    logic signed [ACC_W-1:0] w_shift;
    assign w_shift = w_rnd >>> SHIFT;

    always_comb begin
        o_coef = DW'(w_shift);
        if (w_shift > KMAX) begin
            o_coef = DW'(KMAX);
        end else if (w_shift < KMIN) begin
            o_coef = DW'(KMIN);
        end
    end
`else
    assign o_coef = DW'(w_rnd >>> SHIFT);
`endif

endmodule

// File: rtl/fdct4_serial.sv
// Serial 4-point HEVC forward DCT: load x0..x3, one butterfly cycle, stream y0..y3 with backpressure.
// Build option: FDCT_SAT_EN clamps each coefficient to signed 16-bit.
module fdct4_serial
    import fdct_pkg::*;
#(
    parameter int DW    = 25,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ADD   = DEF_ADD
) (
    input  logic           clk,
    input  logic           reset,
    fdct4_serial_if.slave  bus
);

    state_t               r_state;
    logic [1:0]           r_cnt;
    logic [1:0]           r_idx;
    logic signed [DW-1:0] r_x [4];
    logic signed [DW:0]   r_e0;
    logic signed [DW:0]   r_e1;
    logic signed [DW:0]   r_o0;
    logic signed [DW:0]   r_o1;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_d_out;
    logic                 r_out_last;

    logic signed [DW:0]   w_e0;
    logic signed [DW:0]   w_e1;
    logic signed [DW:0]   w_o0;
    logic signed [DW:0]   w_o1;
    logic [1:0]           w_mac_idx;
    logic signed [DW:0]   w_mac_e0;
    logic signed [DW:0]   w_mac_e1;
    logic signed [DW:0]   w_mac_o0;
    logic signed [DW:0]   w_mac_o1;
    logic signed [DW-1:0] w_coef;

    assign w_e0 = {r_x[0][DW-1], r_x[0]} + {r_x[3][DW-1], r_x[3]};
    assign w_e1 = {r_x[1][DW-1], r_x[1]} + {r_x[2][DW-1], r_x[2]};
    assign w_o0 = {r_x[0][DW-1], r_x[0]} - {r_x[3][DW-1], r_x[3]};
    assign w_o1 = {r_x[1][DW-1], r_x[1]} - {r_x[2][DW-1], r_x[2]};

    // y0 is registered on the BFLY edge from the live butterfly; later beats use the stored terms.
    always_comb begin
        w_mac_idx = r_idx + 2'd1;
        w_mac_e0  = r_e0;
        w_mac_e1  = r_e1;
        w_mac_o0  = r_o0;
        w_mac_o1  = r_o1;
        if (r_state == BFLY) begin
            w_mac_idx = 2'd0;
            w_mac_e0  = w_e0;
            w_mac_e1  = w_e1;
            w_mac_o0  = w_o0;
            w_mac_o1  = w_o1;
        end
    end

    fdct4_coef_mac #(
        .DW    (DW),
        .SHIFT (SHIFT),
        .ADD   (ADD)
    ) u_mac (
        .i_idx  (w_mac_idx),
        .i_e0   (w_mac_e0),
        .i_e1   (w_mac_e1),
        .i_o0   (w_mac_o0),
        .i_o1   (w_mac_o1),
        .o_coef (w_coef)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= LOAD;
            r_cnt       <= 2'd0;
            r_idx       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
            end
            r_e0        <= '0;
            r_e1        <= '0;
            r_o0        <= '0;
            r_o1        <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_x[r_cnt] <= bus.d_in;
                        r_cnt      <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state    <= BFLY;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                BFLY: begin
                    r_e0        <= w_e0;
                    r_e1        <= w_e1;
                    r_o0        <= w_o0;
                    r_o1        <= w_o1;
                    r_d_out     <= w_coef;
                    r_idx       <= 2'd0;
                    r_out_last  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b0;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (r_idx == 2'd3) begin
                            r_state     <= LOAD;
                            r_cnt       <= 2'd0;
                            r_idx       <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_d_out     <= '0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_d_out    <= w_coef;
                            r_out_last <= (r_idx == 2'd2);
                        end
                    end
                end
                default: begin
                    r_state    <= LOAD;
                    r_cnt      <= 2'd0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.d_out     = r_d_out;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_fdct4_serial.sv
// Scoreboard bench for fdct4_serial: directed blocks push expected y0..y3, a monitor pops on each output beat.
module tb_fdct4_serial;

    localparam int DW = 25;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fdct4_serial_if #(.DW(DW)) bus ();

    fdct4_serial #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushBlock(input int y0, input int y1, input int y2, input int y3);
        int ys[4];
        ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.data = ys[i];
            e.idx  = i;
            e.last = (i == 3);
            expQ.push_back(e);
        end
    endtask

    // One input beat: offer at a negedge, hold until in_ready was seen, retire just after the accepting edge.
    task automatic sendSample(input int x);
        int t;
        t = 0;
        @(negedge clk);
        bus.d_in     = DW'(x);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("in_ready_wait", int'(t < 50), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int x0, input int x1, input int x2, input int x3,
                                 input int y0, input int y1, input int y2, input int y3);
        pushBlock(y0, y1, y2, y3);
        sendSample(x0);
        sendSample(x1);
        sendSample(x2);
        sendSample(x3);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((expQ.size() != 0 || bus.out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drain", int'(t < 100), 1);
    endtask

    // Monitor: every accepted output beat is compared against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat: got d_out=%0d with no expected entry",
                         $signed(bus.d_out));
            end else begin
                e = expQ.pop_front();
                checkOutput("d_out", int'($signed(bus.d_out)), e.data);
                checkOutput("out_idx", int'(bus.out_idx), e.idx);
                checkOutput("out_last", int'(bus.out_last), int'(e.last));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int t;
        int bigY0;
        bus.d_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        #1;
        checkOutput("rst_in_ready", int'(bus.in_ready), 0);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_d_out", int'($signed(bus.d_out)), 0);
        checkOutput("rst_out_idx", int'(bus.out_idx), 0);
        checkOutput("rst_out_last", int'(bus.out_last), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] impulse");
        applyStimulus(4096, 0, 0, 0, 64, 83, 64, 36);
        @(negedge clk);
        checkOutput("latency_bfly", int'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("latency_first", int'(bus.out_valid), 1);
        waitDrain();

        $display("[TB] negative impulse");
        applyStimulus(-4096, 0, 0, 0, -64, -83, -64, -36);
        waitDrain();

        $display("[TB] dc");
        applyStimulus(64, 64, 64, 64, 4, 0, 0, 0);
        waitDrain();

        $display("[TB] mixed");
        applyStimulus(100, -200, 300, -400, -3, 6, -6, 15);
        waitDrain();

        $display("[TB] backpressure");
        applyStimulus(4096, 0, 0, 0, 64, 83, 64, 36);
        t = 0;
        while (!(bus.out_valid && bus.out_idx == 2'd1) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("bp_reach_idx1", int'(t < 50), 1);
        bus.out_ready = 1'b0;
        bus.d_in      = DW'(12345);
        bus.in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_d_out", int'($signed(bus.d_out)), 83);
            checkOutput("bp_out_idx", int'(bus.out_idx), 1);
            checkOutput("bp_in_ready", int'(bus.in_ready), 0);
            checkOutput("bp_out_valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain();

        $display("[TB] large input");
`ifdef FDCT_SAT_EN
        bigY0 = 32767;
`else
        bigY0 = 524288;
`endif
        applyStimulus(8388607, 8388607, 8388607, 8388607, bigY0, 0, 0, 0);
        waitDrain();

        $display("[TB] reset during load");
        sendSample(4096);
        sendSample(4096);
        reset = 1'b0;
        #1;
        checkOutput("rstload_in_ready", int'(bus.in_ready), 0);
        checkOutput("rstload_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(100, -200, 300, -400, -3, 6, -6, 15);
        waitDrain();

        $display("[TB] reset during output");
        applyStimulus(-4096, 0, 0, 0, -64, -83, -64, -36);
        t = 0;
        while (!(bus.out_valid && bus.out_idx == 2'd2) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("rstout_reach_idx2", int'(t < 50), 1);
        reset = 1'b0;
        #1;
        expQ.delete();
        checkOutput("rstout_d_out", int'($signed(bus.d_out)), 0);
        checkOutput("rstout_out_valid", int'(bus.out_valid), 0);
        checkOutput("rstout_out_idx", int'(bus.out_idx), 0);
        checkOutput("rstout_out_last", int'(bus.out_last), 0);
        checkOutput("rstout_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(64, 64, 64, 64, 4, 0, 0, 0);
        waitDrain();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdct4_serial.md
Name: fdct4_serial

Overview:
4-point HEVC forward DCT, the encoder-side counterpart of the IDCT datapath. Uses coefficients 64/83/64/36 and round-and-shift output.
Accepts 4 residual samples serially over a valid/ready handshake, runs a butterfly, then streams the 4 coefficients y0..y3 one per beat.
Sits in front of quantisation; its outputs feed the IDCT blocks in loopback tests.

Parameters:
DW, 25, input/output sample width (signed)
SHIFT, 12, right-shift applied after rounding (arithmetic)
ADD, 2048, rounding constant added before shift (must equal 1<<(SHIFT-1))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
d_in  input  DW  signed input sample x0..x3, in order
in_valid  input  1  d_in valid
in_ready  output  1  block can accept d_in
d_out  output  DW  signed coefficient
out_valid  output  1  d_out valid
out_ready  input  1  downstream accepts d_out
out_idx  output  2  index of coefficient on d_out (0..3)
out_last  output  1  high on the y3 beat

Behaviour:
- Reset (reset=0, async): state=LOAD, sample count=0, in_ready=0 while in reset, out_valid=0, d_out=0, out_idx=0, out_last=0. Butterfly registers cleared. Reset mid-block discards all partial data.
- FSM states:
  - LOAD: in_ready=1. Each in_valid&&in_ready beat stores x[cnt] and increments cnt; after the 4th beat go to BFLY.
  - BFLY: one cycle, in_ready=0. Registers e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2 (DW+1 bits). Go to OUT, idx=0.
  - OUT: in_ready=0. Presents y[idx]; on out_ready&&out_valid, idx++. After the idx=3 handshake go to LOAD, cnt=0.
- Coefficients:
  - y0=64*(e0+e1)
  - y1=83*o0+36*o1
  - y2=64*(e0-e1)
  - y3=36*o0-83*o1
- Arithmetic and width:
  - Product/sum is computed at 34 bits signed.
  - d_out = (sum + ADD) >>> SHIFT, arithmetic shift (floor), truncated to DW bits (two's-complement wrap).
- Output register timing:
  - d_out/out_idx/out_last are registered. The first out_valid is asserted the cycle after BFLY.
  - Minimum block period is 9 cycles (4 load, 1 bfly, 4 out) with out_ready held at 1.
- Backpressure: while out_valid=1 and out_ready=0, d_out/out_idx/out_last hold stable; no input is accepted.
- in_valid during BFLY/OUT is ignored (in_ready=0). out_ready while out_valid=0 is ignored.
- out_valid stays 1 continuously across all 4 beats unless reset.

Optional Feature:
FDCT_SAT_EN
- Defined: after the shift, d_out saturates to signed 16-bit range [-32768, 32767], sign-extended to DW.
- Not defined: plain DW-bit truncation as above; no saturation logic is synthesised.

Decomposition:
- Shared package fdct_pkg: coefficient constants C64=64, C83=83, C36=36; ACC_W=34; default SHIFT/ADD; FSM state enum (LOAD, BFLY, OUT).
- One sub-module fdct4_coef_mac: combinational. Inputs: idx, e0/e1/o0/o1. Output: the rounded, shifted (and optionally saturated) coefficient. The top registers its output.

Test Plan:
1. Impulse: x=4096,0,0,0, out_ready=1 -> d_out=64,83,64,36; out_idx 0..3; out_last only on the 4th beat; first out_valid 2 cycles after the 4th input beat.
2. Negative impulse: x=-4096,0,0,0 -> d_out=-64,-83,-64,-36 (checks floor rounding).
3. DC: x=64,64,64,64 -> 4,0,0,0 (checks 16384+2048>>>12=4).
4. Backpressure: out_ready low for 5 cycles on beat idx=1 -> d_out=83 and out_idx=1 held stable, in_ready=0 throughout; the sequence then completes unchanged.
5. Large input: all x=8388607 -> d_out y0=524288 without FDCT_SAT_EN; y0=32767 with it; y1..y3=0 in both builds.
6. Reset mid-block: drive reset=0 after 2 input beats and after the 2nd output beat -> outputs zero immediately; the next full 4-sample block produces correct results with no stale data.
